// File: rtl/rr_arbiter4_pkg.sv
// +----------------------------------------------------------------------+
// | rr_arbiter4_pkg : shared constants and state encoding for rr_arbiter4 |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick4 : combinational round-robin pick, first set req bit at or   |
// |            after ptr (mod 4)                                         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick4
  import rr_arbiter4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic [IDX_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    pick_idx = ptr;
    pick_any = 1'b0;
    w_cand   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ptr + IDX_W'(k);
      if (req[w_cand]) begin
        pick_idx = w_cand;
        pick_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// +----------------------------------------------------------------------+
// | rr_arbiter4 : four-requester round-robin arbiter, registered grant   |
// |               index for the downstream 2-to-4 decoder.               |
// |               Optional hold timeout: define ARB_TIMEOUT_EN.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   ptr
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_param_check
    $error("rr_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_valid, w_valid_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_holder_req;
  logic             w_timeout;

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .pick_idx (w_pick_idx),
    .pick_any (w_pick_any)
  );

  assign w_holder_req = req[r_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] w_holder_mask;
  logic               w_others;

  assign w_holder_mask = NUM_REQ'(1) << r_idx;
  assign w_others      = |(req & ~w_holder_mask);
  assign w_timeout     = (r_cnt == CNT_W'(MAX_HOLD)) && w_others;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ST_IDLE) begin
      w_cnt_nxt = '0;
    end else if (r_cnt != CNT_W'(MAX_HOLD)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next state; a grant is only ever released back to IDLE, which forces
  // the one-cycle gap between consecutive grants.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ptr_nxt   = r_ptr;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (en && w_pick_any) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_pick_idx;
          w_ptr_nxt   = w_pick_idx + IDX_W'(1);
          w_valid_nxt = 1'b1;
        end
      end
      ST_GRANT: begin
        w_valid_nxt = 1'b1;
        if (!w_holder_req || w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign ptr       = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// +----------------------------------------------------------------------+
// | tb_rr_arbiter4 : directed self-checking bench for rr_arbiter4        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [1:0] ptr;

  int checks = 0;
  int errors = 0;

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [1:0] i,
                            input logic [1:0] p);
    chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, v});
    chk({tag, ".idx"},   {6'd0, gnt_idx},   {6'd0, i});
    chk({tag, ".ptr"},   {6'd0, ptr},       {6'd0, p});
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;

    // reset held with all requests active
    tick(); expect_out("rst0", 1'b0, 2'd0, 2'd0);
    tick(); expect_out("rst1", 1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
    tick(); expect_out("first", 1'b1, 2'd0, 2'd1);

    // rotation 0,1,2,3,0 with one gap cycle each
    for (int g = 0; g < 4; g++) begin
      tick(); expect_out("rot_hold_a", 1'b1, 2'(g), 2'(g + 1));
      tick(); expect_out("rot_hold_b", 1'b1, 2'(g), 2'(g + 1));
      req[g] = 1'b0;
      tick(); expect_out("rot_gap", 1'b0, 2'(g), 2'(g + 1));
      req[g] = 1'b1;
      tick(); expect_out("rot_next", 1'b1, 2'(g + 1), 2'(g + 2));
    end

    // skip and wrap
    req = 4'b0000; tick(); expect_out("sw_rel0", 1'b0, 2'd0, 2'd1);
    req = 4'b0100; tick(); expect_out("sw_g2",   1'b1, 2'd2, 2'd3);
    req = 4'b0000; tick(); expect_out("sw_rel1", 1'b0, 2'd2, 2'd3);
    req = 4'b0010; tick(); expect_out("sw_g1",   1'b1, 2'd1, 2'd2);
    req = 4'b0000; tick(); expect_out("sw_rel2", 1'b0, 2'd1, 2'd2);
    req = 4'b1001; tick(); expect_out("sw_g3",   1'b1, 2'd3, 2'd0);
    req = 4'b0000; tick(); expect_out("sw_rel3", 1'b0, 2'd3, 2'd0);

    // enable gating
    en  = 1'b0;
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      tick(); expect_out("en_block", 1'b0, 2'd3, 2'd0);
    end
    en = 1'b1;
    tick(); expect_out("en_grant", 1'b1, 2'd2, 2'd3);
    en = 1'b0;
    tick(); expect_out("en_drop_a", 1'b1, 2'd2, 2'd3);
    tick(); expect_out("en_drop_b", 1'b1, 2'd2, 2'd3);
    req = 4'b0000;
    tick(); expect_out("en_rel", 1'b0, 2'd2, 2'd3);
    en = 1'b1;

    // reset mid-grant
    req = 4'b0010;
    tick(); expect_out("mr_g1", 1'b1, 2'd1, 2'd2);
    rst_n = 1'b0;
    tick(); expect_out("mr_rst", 1'b0, 2'd0, 2'd0);
    rst_n = 1'b1;
    req   = 4'b0000;
    tick(); expect_out("mr_idle", 1'b0, 2'd0, 2'd0);

    // single requester re-granted after each gap
    req = 4'b0001; tick(); expect_out("single_g0",  1'b1, 2'd0, 2'd1);
    req = 4'b0000; tick(); expect_out("single_rel", 1'b0, 2'd0, 2'd1);
    req = 4'b0001; tick(); expect_out("single_g0b", 1'b1, 2'd0, 2'd1);
    req = 4'b0000; tick(); expect_out("single_idle", 1'b0, 2'd0, 2'd1);

`ifdef ARB_TIMEOUT_EN
    // revoke after four held cycles while client 2 waits
    req = 4'b0001; tick(); expect_out("to_g0", 1'b1, 2'd0, 2'd1);
    req = 4'b0101;
    for (int c = 0; c < 4; c++) begin
      tick(); expect_out("to_hold", 1'b1, 2'd0, 2'd1);
    end
    tick(); expect_out("to_revoke", 1'b0, 2'd0, 2'd1);
    tick(); expect_out("to_g2", 1'b1, 2'd2, 2'd3);
    req = 4'b0000; tick(); expect_out("to_rel", 1'b0, 2'd2, 2'd3);
    // lone holder is never revoked
    req = 4'b0001; tick(); expect_out("to_lone_g0", 1'b1, 2'd0, 2'd1);
    for (int c = 0; c < 12; c++) begin
      tick(); expect_out("to_lone_hold", 1'b1, 2'd0, 2'd1);
    end
    req = 4'b0000; tick(); expect_out("to_lone_rel", 1'b0, 2'd0, 2'd1);
`else
    // unbounded hold: others waiting have no effect until the holder drops
    req = 4'b0001; tick(); expect_out("ub_g0", 1'b1, 2'd0, 2'd1);
    req = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      tick(); expect_out("ub_hold", 1'b1, 2'd0, 2'd1);
    end
    req = 4'b0100;
    tick(); expect_out("ub_rel", 1'b0, 2'd0, 2'd1);
    tick(); expect_out("ub_g2",  1'b1, 2'd2, 2'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
